// File: rtl/noc_flit_packetizer.sv
// NoC source packetizer: turns a packet request plus body words into HEAD/BODY/TAIL
// flits, with credit-based flow control against the downstream input buffer.
module noc_flit_packetizer #(
    parameter int BUFFER_SIZE    = 8,
    parameter int X_DEST_W       = 2,
    parameter int Y_DEST_W       = 2,
    parameter int HEAD_PAYLOAD_W = 28,
    parameter int LEN_W          = 4,
    localparam int FLIT_DATA_W   = X_DEST_W + Y_DEST_W + HEAD_PAYLOAD_W,
    localparam int CNT_W         = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    input  logic [X_DEST_W-1:0]       pkt_x_dest,
    input  logic [Y_DEST_W-1:0]       pkt_y_dest,
    input  logic [HEAD_PAYLOAD_W-1:0] pkt_head_payload,
    input  logic [LEN_W-1:0]          pkt_len,
    input  logic                      data_valid,
    output logic                      data_ready,
    input  logic [FLIT_DATA_W-1:0]    data_in,
    output logic                      flit_valid,
    output logic [1:0]                flit_label,
    output logic [FLIT_DATA_W-1:0]    flit_data,
    input  logic                      credit_in,
    output logic [CNT_W-1:0]          credit_cnt,
    output logic                      credit_overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [1:0] LBL_HEAD     = 2'b00;
    localparam logic [1:0] LBL_BODY     = 2'b01;
    localparam logic [1:0] LBL_TAIL     = 2'b10;
    localparam logic [1:0] LBL_HEADTAIL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUFFER_SIZE);

    logic [1:0]                state;
    logic [X_DEST_W-1:0]       x_q;
    logic [Y_DEST_W-1:0]       y_q;
    logic [HEAD_PAYLOAD_W-1:0] hp_q;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          rem_q;

    logic has_credit;
    logic issue_head;
    logic issue_body;
    logic issue;
    logic last_body;

    always_comb begin
        has_credit = (credit_cnt != '0);
        pkt_ready  = (state == ST_IDLE);
        data_ready = (state == ST_BODY) && has_credit;
        issue_head = (state == ST_HEAD) && has_credit;
        issue_body = data_ready && data_valid;
        issue      = issue_head || issue_body;
        last_body  = (rem_q == LEN_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            x_q             <= '0;
            y_q             <= '0;
            hp_q            <= '0;
            len_q           <= '0;
            rem_q           <= '0;
            flit_valid      <= 1'b0;
            flit_label      <= LBL_HEAD;
            flit_data       <= '0;
            credit_cnt      <= CNT_MAX;
            credit_overflow <= 1'b0;
        end else begin
            flit_valid <= issue;

            unique case (state)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        x_q   <= pkt_x_dest;
                        y_q   <= pkt_y_dest;
                        hp_q  <= pkt_head_payload;
                        len_q <= pkt_len;
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (issue_head) begin
                        flit_label <= (len_q == '0) ? LBL_HEADTAIL : LBL_HEAD;
                        flit_data  <= {x_q, y_q, hp_q};
                        rem_q      <= len_q;
                        state      <= (len_q == '0) ? ST_IDLE : ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (issue_body) begin
                        flit_label <= last_body ? LBL_TAIL : LBL_BODY;
                        flit_data  <= data_in;
                        rem_q      <= rem_q - LEN_W'(1);
                        if (last_body) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A returned credit and an issue in the same cycle cancel out.
            if (issue && !credit_in) begin
                credit_cnt <= credit_cnt - CNT_W'(1);
            end else if (credit_in && !issue) begin
                if (credit_cnt == CNT_MAX) credit_overflow <= 1'b1;
                else credit_cnt <= credit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_noc_flit_packetizer.sv
// Directed self-checking bench for noc_flit_packetizer.
// Flits are logged on the falling edge and compared against hand-computed values.
module tb_noc_flit_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [1:0]  pkt_x_dest = '0;
    logic [1:0]  pkt_y_dest = '0;
    logic [27:0] pkt_head_payload = '0;
    logic [3:0]  pkt_len = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data_in = '0;
    logic        flit_valid;
    logic [1:0]  flit_label;
    logic [31:0] flit_data;
    logic        credit_in = 1'b0;
    logic [3:0]  credit_cnt;
    logic        credit_overflow;

    noc_flit_packetizer dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid        (pkt_valid),
        .pkt_ready        (pkt_ready),
        .pkt_x_dest       (pkt_x_dest),
        .pkt_y_dest       (pkt_y_dest),
        .pkt_head_payload (pkt_head_payload),
        .pkt_len          (pkt_len),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .data_in          (data_in),
        .flit_valid       (flit_valid),
        .flit_label       (flit_label),
        .flit_data        (flit_data),
        .credit_in        (credit_in),
        .credit_cnt       (credit_cnt),
        .credit_overflow  (credit_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int nflits = 0;
    int n0;
    int c0;
    logic [1:0]  f_lbl [64];
    logic [31:0] f_dat [64];
    int          f_cyc [64];
    logic [31:0] words [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (flit_valid && nflits < 64) begin
            f_lbl[nflits] = flit_label;
            f_dat[nflits] = flit_data;
            f_cyc[nflits] = cyc;
            nflits++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Accept one packet, stream its body words from words[], wait for the last flit.
    task automatic send_pkt(input logic [1:0] x, input logic [1:0] y,
                            input logic [27:0] hp, input int len);
        int b;
        pkt_x_dest = x;
        pkt_y_dest = y;
        pkt_head_payload = hp;
        pkt_len = 4'(len);
        pkt_valid = 1'b1;
        b = 0;
        while (!pkt_ready && b < 50) begin
            tick();
            b++;
        end
        chk("pkt_accept", {63'd0, pkt_ready}, 64'd1);
        tick();
        pkt_valid = 1'b0;
        if (len == 0) tick();
        for (int i = 0; i < len; i++) begin
            data_valid = 1'b1;
            data_in = words[i];
            b = 0;
            while (!data_ready && b < 50) begin
                tick();
                b++;
            end
            if (!data_ready) chk("data_wait", {63'd0, data_ready}, 64'd1);
            tick();
        end
        data_valid = 1'b0;
        tick();
    endtask

    initial begin
        // T1: reset values
        tick();
        tick();
        chk("rst_cnt", 64'(credit_cnt), 64'd8);
        chk("rst_pkt_ready", 64'(pkt_ready), 64'd1);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_flit_valid", 64'(flit_valid), 64'd0);
        chk("rst_overflow", 64'(credit_overflow), 64'd0);
        chk("rst_label", 64'(flit_label), 64'd0);
        chk("rst_data", 64'(flit_data), 64'd0);
        rst = 1'b0;
        tick();

        // T2: single HEADTAIL flit
        n0 = nflits;
        send_pkt(2'd1, 2'd2, 28'hABC, 0);
        chk("t2_nflits", 64'(nflits - n0), 64'd1);
        chk("t2_label", 64'(f_lbl[n0]), 64'd3);
        chk("t2_data", 64'(f_dat[n0]), 64'h6000_0ABC);
        chk("t2_cnt", 64'(credit_cnt), 64'd7);
        chk("t2_idle", 64'(pkt_ready), 64'd1);

        // T3: HEAD + 3 body words back-to-back
        do_reset();
        n0 = nflits;
        words[0] = 32'h11;
        words[1] = 32'h22;
        words[2] = 32'h33;
        send_pkt(2'd3, 2'd0, 28'h0000123, 3);
        chk("t3_nflits", 64'(nflits - n0), 64'd4);
        chk("t3_lbl0", 64'(f_lbl[n0]), 64'd0);
        chk("t3_dat0", 64'(f_dat[n0]), 64'hC000_0123);
        chk("t3_lbl1", 64'(f_lbl[n0+1]), 64'd1);
        chk("t3_dat1", 64'(f_dat[n0+1]), 64'h11);
        chk("t3_lbl2", 64'(f_lbl[n0+2]), 64'd1);
        chk("t3_dat2", 64'(f_dat[n0+2]), 64'h22);
        chk("t3_lbl3", 64'(f_lbl[n0+3]), 64'd2);
        chk("t3_dat3", 64'(f_dat[n0+3]), 64'h33);
        chk("t3_b2b", 64'(f_cyc[n0+3] - f_cyc[n0]), 64'd3);
        chk("t3_cnt", 64'(credit_cnt), 64'd4);

        // T5: credit_in coincident with issue, then overflow
        n0 = nflits;
        pkt_x_dest = 2'd0;
        pkt_y_dest = 2'd1;
        pkt_head_payload = 28'h5;
        pkt_len = 4'd0;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("t5_coinc_cnt", 64'(credit_cnt), 64'd4);
        tick();
        chk("t5_coinc_flit", 64'(nflits - n0), 64'd1);
        chk("t5_coinc_data", 64'(f_dat[n0]), 64'h1000_0005);
        credit_in = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        credit_in = 1'b0;
        chk("t5_full_cnt", 64'(credit_cnt), 64'd8);
        chk("t5_no_ovf", 64'(credit_overflow), 64'd0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("t5_ovf", 64'(credit_overflow), 64'd1);
        chk("t5_ovf_cnt", 64'(credit_cnt), 64'd8);
        for (int i = 0; i < 3; i++) tick();
        chk("t5_ovf_sticky", 64'(credit_overflow), 64'd1);

        // T4: credit exhaustion across three len=2 packets
        do_reset();
        chk("t4_ovf_clr", 64'(credit_overflow), 64'd0);
        n0 = nflits;
        data_valid = 1'b1;
        data_in = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            chk("t4_idle_dready", 64'(data_ready), 64'd0);
            tick();
        end
        data_valid = 1'b0;
        tick();
        chk("t4_idle_noflit", 64'(nflits - n0), 64'd0);
        words[0] = 32'hA1;
        words[1] = 32'hA2;
        send_pkt(2'd1, 2'd1, 28'h1, 2);
        words[0] = 32'hB1;
        words[1] = 32'hB2;
        send_pkt(2'd2, 2'd2, 28'h2, 2);
        chk("t4_cnt_mid", 64'(credit_cnt), 64'd2);
        pkt_x_dest = 2'd3;
        pkt_y_dest = 2'd3;
        pkt_head_payload = 28'h3;
        pkt_len = 4'd2;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        data_valid = 1'b1;
        data_in = 32'hC1;
        tick();
        tick();
        data_in = 32'hC2;
        tick();
        tick();
        chk("t4_stall_dready", 64'(data_ready), 64'd0);
        chk("t4_stall_nflits", 64'(nflits - n0), 64'd8);
        chk("t4_stall_cnt", 64'(credit_cnt), 64'd0);
        chk("t4_stall_lbl", 64'(f_lbl[n0+7]), 64'd1);
        chk("t4_stall_dat", 64'(f_dat[n0+7]), 64'hC1);
        credit_in = 1'b1;
        c0 = cyc;
        tick();
        credit_in = 1'b0;
        tick();
        data_valid = 1'b0;
        tick();
        chk("t4_tail_nflits", 64'(nflits - n0), 64'd9);
        chk("t4_tail_lbl", 64'(f_lbl[n0+8]), 64'd2);
        chk("t4_tail_dat", 64'(f_dat[n0+8]), 64'hC2);
        chk("t4_tail_lat", 64'(f_cyc[n0+8] - c0), 64'd2);
        chk("t4_tail_cnt", 64'(credit_cnt), 64'd0);

        // T6: reset in the middle of a packet
        credit_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        credit_in = 1'b0;
        chk("t6_refill", 64'(credit_cnt), 64'd8);
        n0 = nflits;
        pkt_x_dest = 2'd2;
        pkt_y_dest = 2'd1;
        pkt_head_payload = 28'h77;
        pkt_len = 4'd4;
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
        data_valid = 1'b1;
        data_in = 32'hD1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_fv", 64'(flit_valid), 64'd0);
        chk("t6_rst_lbl", 64'(flit_label), 64'd0);
        chk("t6_rst_dat", 64'(flit_data), 64'd0);
        chk("t6_rst_cnt", 64'(credit_cnt), 64'd8);
        chk("t6_rst_prdy", 64'(pkt_ready), 64'd1);
        chk("t6_rst_drdy", 64'(data_ready), 64'd0);
        data_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        n0 = nflits;
        words[0] = 32'hE1;
        send_pkt(2'd0, 2'd3, 28'h99, 1);
        chk("t6_nflits", 64'(nflits - n0), 64'd2);
        chk("t6_head_lbl", 64'(f_lbl[n0]), 64'd0);
        chk("t6_head_dat", 64'(f_dat[n0]), 64'h3000_0099);
        chk("t6_tail_lbl", 64'(f_lbl[n0+1]), 64'd2);
        chk("t6_tail_dat", 64'(f_dat[n0+1]), 64'hE1);
        chk("t6_cnt", 64'(credit_cnt), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
